// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared CPU definitions for the fetch stage: FSM state encoding, the NOP
// instruction word and a small alignment helper.
package inst_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: drives the PC to an external combinational
// instruction memory and fills the IF/ID register with valid/ready flow control.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        halted,
  output logic        err_misalign,
  output logic [15:0] fetch_count
);

  localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

  fetch_state_t state, state_next;
  logic [31:0]  pc;
  logic         reg_free, pc_in_range, handshake;
  logic         redir_ok, redir_bad;
  logic         do_capture, do_drop;

  assign reg_free    = !id_valid || id_ready;
  assign pc_in_range = pc[31:2] < IMEM_LIMIT;
  assign handshake   = id_valid && id_ready;
  assign redir_ok    = redirect_valid &&  is_word_aligned(redirect_pc);
  assign redir_bad   = redirect_valid && !is_word_aligned(redirect_pc);

  assign imem_addr = pc;
  assign halted    = (state == ST_HALT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    if (redir_ok) begin
      state_next = ST_RUN;
    end else if (redir_bad) begin
      state_next = ST_HALT;
    end else begin
      unique case (state)
        ST_IDLE: state_next = ST_RUN;
        ST_RUN:  if (reg_free && !pc_in_range) state_next = ST_HALT;
        ST_HALT: state_next = ST_HALT;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Redirects flush the IF/ID register regardless of state or stall.
  always_comb begin
    do_capture = 1'b0;
    do_drop    = 1'b0;
    if (redirect_valid) begin
      do_drop = 1'b1;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (reg_free) begin
            do_capture = pc_in_range;
            do_drop    = !pc_in_range;
          end
        end
        default: do_drop = reg_free;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      id_valid     <= 1'b0;
      id_inst      <= NOP;
      id_pc        <= 32'h0;
      err_misalign <= 1'b0;
      fetch_count  <= 16'h0;
    end else begin
      if (redir_ok)        pc <= redirect_pc;
      else if (do_capture) pc <= pc + 32'd4;

      if (do_capture) begin
        id_inst  <= imem_inst;
        id_pc    <= pc;
        id_valid <= 1'b1;
      end else if (do_drop) begin
        id_valid <= 1'b0;
      end

      if (redir_ok)       err_misalign <= 1'b0;
      else if (redir_bad) err_misalign <= 1'b1;

      if (handshake && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
    end
  end

endmodule

// File: doc/inst_fetch_ctrl.md
INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have parameter IMEM_WORDS, default 17, meaning the number of valid instruction-memory words.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning the asynchronous, active-low reset.
REQ-005 SHALL have port imem_addr, output, 32, meaning the byte address driven to the instruction memory (word index = addr[31:2]).
REQ-006 SHALL have port imem_inst, input, 32, meaning the combinational read data returned for imem_addr in the same cycle.
REQ-007 SHALL have port redirect_valid, input, 1, meaning a jump or branch-taken request from execute.
REQ-008 SHALL have port redirect_pc, input, 32, meaning the target byte address, sampled when redirect_valid=1.
REQ-009 SHALL have port id_ready, input, 1, meaning decode accepts the IF/ID register this cycle.
REQ-010 SHALL have port id_valid, output, 1, meaning the IF/ID register holds a live instruction.
REQ-011 SHALL have port id_inst, output, 32, meaning the fetched instruction.
REQ-012 SHALL have port id_pc, output, 32, meaning the byte address of id_inst.
REQ-013 SHALL have port halted, output, 1, meaning the FSM is in HALT.
REQ-014 SHALL have port err_misalign, output, 1, meaning the last redirect target had addr[1:0]!=0 (sticky until the next valid redirect).
REQ-015 SHALL have port fetch_count, output, 16, meaning the number of id_valid&&id_ready handshakes, saturating at 16'hFFFF.

Function
REQ-016 SHALL drive imem_addr = pc combinationally; pc is an internal 32-bit register.
REQ-017 SHALL implement FSM states IDLE, RUN and HALT; reset enters IDLE; IDLE -> RUN unconditionally after one cycle, with no capture in IDLE.
REQ-018 SHALL, in RUN with the IF/ID register free (!id_valid || id_ready) and no redirect, load id_inst<=imem_inst, id_pc<=pc, id_valid<=1, pc<=pc+4 (modulo 2^32).
REQ-019 SHALL, when id_valid && !id_ready, hold id_inst, id_pc, id_valid and pc unchanged (stall).
REQ-020 SHALL give redirect_valid priority over fetch and stall in every state: with aligned target, pc<=redirect_pc, id_valid<=0 next cycle, err_misalign<=0, state<=RUN.
REQ-021 SHALL treat a redirect with redirect_pc[1:0]!=0 as fatal: pc unchanged, id_valid<=0, err_misalign<=1, state<=HALT.
REQ-022 SHALL, in RUN with the register free and pc[31:2] >= IMEM_WORDS, perform no capture, set id_valid<=0 and enter HALT.
REQ-023 SHALL, in HALT, perform no fetch and leave HALT only through an aligned redirect.
REQ-024 SHALL count a handshake in fetch_count in the same cycle it retires, in any state.
REQ-025 SHALL accept a handshake and a redirect in the same cycle; the handshake counts and the redirect takes effect.
REQ-026 SHALL have a steady-state throughput of one instruction per cycle, with one-cycle latency from imem_addr to id_inst.

Reset
REQ-027 SHALL, on rst_n=0, asynchronously set pc=RESET_PC, id_valid=0, id_inst=0, id_pc=0, halted=0, err_misalign=0, fetch_count=0, state=IDLE.
REQ-028 SHALL abandon any in-flight fetch or stall when reset asserts mid-operation, with nothing retained.

Structure
REQ-029 SHALL place the FSM state encoding (IDLE/RUN/HALT) and the NOP constant 32'h0 in the shared CPU package.
REQ-030 SHALL be a single module with no sub-modules; the instruction memory stays external.

Verification
REQ-031 SHALL cover: reset release, id_ready=1 -> id_pc sequence 0,4,8,... one per cycle, first id_valid on the 2nd edge after release.
REQ-032 SHALL cover: id_ready=0 for 3 cycles at id_pc=8 -> id_pc/id_inst held at 8, pc held at 12, fetch_count frozen.
REQ-033 SHALL cover: redirect_valid=1, redirect_pc=16 with id_valid=1, id_ready=1 -> fetch_count increments, id_valid=0 next cycle, then id_pc=16.
REQ-034 SHALL cover: redirect_pc=32'h6 -> halted=1, err_misalign=1, no further fetches until redirect_pc=16.
REQ-035 SHALL cover: IMEM_WORDS=17, free run -> last id_pc=64, then halted=1, id_valid=0.
REQ-036 SHALL cover: rst_n pulsed low mid-stall -> all outputs at reset values immediately, without waiting for a clock edge.
